// File: rtl/spi_tx_scheduler_if.sv
// Start/done handshake bundle between the transmit scheduler and the spi shifter.
interface spi_tx_scheduler_if;
    logic       spi_start;
    logic [7:0] spi_data;
    logic       spi_sel;
    logic       spi_done;

    modport master (
        output spi_start,
        output spi_data,
        output spi_sel,
        input  spi_done
    );

    modport slave (
        input  spi_start,
        input  spi_data,
        input  spi_sel,
        output spi_done
    );
endinterface

// File: rtl/spi_tx_scheduler.sv
// Queues {sel,data} byte requests and issues them one at a time to the spi
// shifter, with a done-timeout watchdog, transmit pause and sticky error flags.
module spi_tx_scheduler #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [7:0]          wr_data,
    input  logic                wr_sel,
    input  logic                tx_enable,
    input  logic                err_clr,
    output logic                full,
    output logic                empty,
    output logic [ADDR_W:0]     count,
    output logic                busy,
    output logic                overflow,
    output logic                timeout_err,
    spi_tx_scheduler_if.master  spi
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

    state_t              state_reg;
    logic [8:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_reg;
    logic [ADDR_W-1:0]   rd_ptr_reg;
    logic [ADDR_W:0]     count_reg;
    logic [ADDR_W:0]     count_next;
    logic                full_reg;
    logic                empty_reg;
    logic                busy_reg;
    logic                overflow_reg;
    logic                timeout_err_reg;
    logic                spi_start_reg;
    logic [7:0]          spi_data_reg;
    logic                spi_sel_reg;
    logic [WD_W-1:0]     wd_reg;
    logic                push;
    logic                pop;
    logic                timeout_hit;

    // Fullness is judged on the pre-edge state, so a same-cycle pop never frees a slot.
    assign push        = wr_en && !full_reg;
    assign pop         = (state_reg == IDLE) && tx_enable && !empty_reg;
    assign timeout_hit = (state_reg == WAIT_DONE) && !spi.spi_done && (wd_reg == WD_LAST);

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (!push && pop) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {wr_sel, wr_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
            full_reg  <= (count_next == CNT_FULL);
            empty_reg <= (count_next == '0);
        end
    end

    // A set event in the same cycle as err_clr takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg    <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            overflow_reg    <= (overflow_reg && !err_clr) || (wr_en && full_reg);
            timeout_err_reg <= (timeout_err_reg && !err_clr) || timeout_hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            spi_start_reg <= 1'b0;
            spi_data_reg  <= 8'h00;
            spi_sel_reg   <= 1'b0;
            wd_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    spi_start_reg <= 1'b0;
                    if (pop) begin
                        spi_data_reg <= mem[rd_ptr_reg][7:0];
                        spi_sel_reg  <= mem[rd_ptr_reg][8];
                        busy_reg     <= 1'b1;
                        state_reg    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Start pulse occupies the first WAIT_DONE cycle, sampled by the spi at the next edge.
                    spi_start_reg <= 1'b1;
                    wd_reg        <= '0;
                    state_reg     <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    spi_start_reg <= 1'b0;
                    if (spi.spi_done || timeout_hit) begin
                        state_reg <= GAP;
                    end else begin
                        wd_reg <= wd_reg + 1'b1;
                    end
                end
                GAP: begin
                    spi_start_reg <= 1'b0;
                    if (!spi.spi_done) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    spi_start_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign full          = full_reg;
    assign empty         = empty_reg;
    assign count         = count_reg;
    assign busy          = busy_reg;
    assign overflow      = overflow_reg;
    assign timeout_err   = timeout_err_reg;
    assign spi.spi_start = spi_start_reg;
    assign spi.spi_data  = spi_data_reg;
    assign spi.spi_sel   = spi_sel_reg;

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Directed bench for spi_tx_scheduler with a small spi responder model.
module tb_spi_tx_scheduler;

    localparam int DEPTH   = 8;
    localparam int ADDR_W  = 3;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [7:0]       wr_data = 8'h00;
    logic             wr_sel = 1'b0;
    logic             tx_enable = 1'b0;
    logic             err_clr = 1'b0;
    logic             full;
    logic             empty;
    logic [ADDR_W:0]  count;
    logic             busy;
    logic             overflow;
    logic             timeout_err;

    spi_tx_scheduler_if sif();

    spi_tx_scheduler #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_sel      (wr_sel),
        .tx_enable   (tx_enable),
        .err_clr     (err_clr),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .busy        (busy),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .spi         (sif.master)
    );

    always #5 clk = ~clk;

    // spi responder: latches the byte on start, raises done after done_delay cycles for done_len cycles.
    int         done_delay = 3;
    int         done_len   = 1;
    bit         done_en    = 1'b1;
    int         cd;
    int         hold;
    logic [7:0] data_out1;
    logic [7:0] data_out2;
    int         viol = 0;
    int         start_cnt = 0;
    logic [8:0] log_mem [0:63];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd            <= 0;
            hold          <= 0;
            sif.spi_done  <= 1'b0;
            data_out1     <= 8'h00;
            data_out2     <= 8'h00;
        end else if (sif.spi_start) begin
            cd <= done_delay;
            if (sif.spi_sel) data_out2 <= sif.spi_data;
            else             data_out1 <= sif.spi_data;
        end else if (cd > 1) begin
            cd <= cd - 1;
        end else if (cd == 1) begin
            cd <= 0;
            if (done_en) begin
                sif.spi_done <= 1'b1;
                hold         <= done_len - 1;
            end
        end else if (sif.spi_done) begin
            if (hold > 0) hold <= hold - 1;
            else          sif.spi_done <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (sif.spi_start) begin
            log_mem[start_cnt] <= {sif.spi_sel, sif.spi_data};
            start_cnt          <= start_cnt + 1;
            if (cd != 0 || sif.spi_done) viol <= viol + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int max);
        int k = 0;
        while (!(!busy && empty) && k < max) begin
            tick();
            k++;
        end
        check(tag, {31'd0, (!busy && empty)}, 32'd1);
    endtask

    task automatic write1(input logic [7:0] d, input logic s);
        wr_en   = 1'b1;
        wr_data = d;
        wr_sel  = s;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=no_finish expected=finish");
        $fatal(1);
    end

    initial begin
        int base;
        int k;
        int level_bad;

        // Reset state
        tick(2);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        check("rst_tmo", timeout_err, 0);
        check("rst_start", sif.spi_start, 0);
        check("rst_data", sif.spi_data, 8'h00);
        check("rst_sel", sif.spi_sel, 0);
        rst_n = 1'b1;
        tx_enable = 1'b1;
        tick();

        // Single transfer, latency and payload
        $display("T1 single write F0 sel1");
        done_delay = 20;
        base = start_cnt;
        write1(8'hF0, 1'b1);
        check("t1_count_e0", count, 1);
        check("t1_empty_e0", empty, 0);
        check("t1_start_e0", sif.spi_start, 0);
        tick();
        check("t1_busy_e1", busy, 1);
        check("t1_data_e1", sif.spi_data, 8'hF0);
        check("t1_sel_e1", sif.spi_sel, 1);
        check("t1_start_e1", sif.spi_start, 0);
        check("t1_empty_e1", empty, 1);
        tick();
        check("t1_start_e2", sif.spi_start, 1);
        tick();
        check("t1_start_e3", sif.spi_start, 0);
        wait_idle("t1_idle", 100);
        check("t1_out2", data_out2, 8'hF0);
        check("t1_out1", data_out1, 8'h00);
        check("t1_starts", start_cnt - base, 1);

        // Three back-to-back writes
        $display("T2 three writes 55 FF A5");
        done_delay = 3;
        base = start_cnt;
        write1(8'h55, 1'b0);
        check("t2_count_a", count, 1);
        write1(8'hFF, 1'b0);
        check("t2_count_b", count, 1);
        write1(8'hA5, 1'b1);
        check("t2_count_c", count, 2);
        tick();
        check("t2_count_d", count, 2);
        k = 0;
        while (start_cnt - base < 3 && k < 200) begin tick(); k++; end
        wait_idle("t2_idle", 100);
        check("t2_starts", start_cnt - base, 3);
        check("t2_log0", log_mem[base],   {1'b0, 8'h55});
        check("t2_log1", log_mem[base+1], {1'b0, 8'hFF});
        check("t2_log2", log_mem[base+2], {1'b1, 8'hA5});
        check("t2_ovf", overflow, 0);
        check("t2_viol", viol, 0);

        // Overflow with transmit paused
        $display("T3 overflow with tx paused");
        tx_enable = 1'b0;
        base = start_cnt;
        for (int i = 0; i < 9; i++) begin
            write1(8'h10 + 8'(i), i[0]);
        end
        check("t3_count", count, 8);
        check("t3_full", full, 1);
        check("t3_ovf", overflow, 1);
        check("t3_nostart", start_cnt - base, 0);
        tx_enable = 1'b1;
        k = 0;
        while (start_cnt - base < 8 && k < 400) begin tick(); k++; end
        wait_idle("t3_idle", 100);
        tick(10);
        check("t3_starts", start_cnt - base, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_log%0d", i), log_mem[base+i], {i[0], 8'h10 + 8'(i)});
        end
        check("t3_ovf_sticky", overflow, 1);
        check("t3_full_after", full, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3_ovf_clr", overflow, 0);

        // Done timeout
        $display("T4 timeout 3C then C3");
        done_en = 1'b0;
        base = start_cnt;
        write1(8'h3C, 1'b0);
        tick();
        tick();
        check("t4_start", sif.spi_start, 1);
        write1(8'hC3, 1'b0);
        check("t4_queued", count, 1);
        tick(62);
        check("t4_tmo_early", timeout_err, 0);
        tick();
        check("t4_tmo_set", timeout_err, 1);
        done_en = 1'b1;
        wait_idle("t4_idle", 100);
        check("t4_starts", start_cnt - base, 2);
        check("t4_log0", log_mem[base],   {1'b0, 8'h3C});
        check("t4_log1", log_mem[base+1], {1'b0, 8'hC3});
        check("t4_tmo_sticky", timeout_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t4_tmo_clr", timeout_err, 0);

        // Level done held for several cycles
        $display("T5 level done 77");
        done_len = 5;
        base = start_cnt;
        level_bad = 0;
        write1(8'h77, 1'b1);
        k = 0;
        while (!sif.spi_done && k < 40) begin tick(); k++; end
        check("t5_done_seen", sif.spi_done, 1);
        k = 0;
        while (sif.spi_done && k < 20) begin
            if (!busy || sif.spi_start) level_bad++;
            tick();
            k++;
        end
        check("t5_gap_hold", busy, 1);
        tick();
        check("t5_gap_exit", busy, 0);
        check("t5_level_bad", level_bad, 0);
        check("t5_starts", start_cnt - base, 1);
        check("t5_out2", data_out2, 8'h77);
        done_len = 1;

        // Reset mid-transfer
        $display("T6 reset during WAIT_DONE");
        done_en = 1'b0;
        base = start_cnt;
        for (int i = 0; i < 5; i++) begin
            write1(8'h60 + 8'(i), 1'b1);
        end
        check("t6_count_pre", count, 4);
        check("t6_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_start", sif.spi_start, 0);
        check("t6_rst_count", count, 0);
        check("t6_rst_empty", empty, 1);
        check("t6_rst_full", full, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_data", sif.spi_data, 8'h00);
        check("t6_rst_sel", sif.spi_sel, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_en = 1'b1;
        tick(10);
        check("t6_no_issue", start_cnt - base, 1);
        check("t6_idle_busy", busy, 0);
        write1(8'h9A, 1'b1);
        wait_idle("t6_idle", 100);
        check("t6_starts", start_cnt - base, 2);
        check("t6_log", log_mem[base+1], {1'b1, 8'h9A});
        check("t6_viol", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
